// File: rtl/spram_byte_write_arb2_if.sv
// One request/response channel of the shared byte-write RAM front end.
interface spram_byte_write_arb2_if #(
  parameter int AW        = 10,
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8
);
  localparam int DW = NB_COL * COL_WIDTH;

  logic              req;
  logic              ready;
  logic [AW-1:0]     addr;
  logic [NB_COL-1:0] wbe;
  logic [DW-1:0]     wdata;
  logic              rvalid;
  logic [DW-1:0]     rdata;

  modport master (output req, addr, wbe, wdata, input ready, rvalid, rdata);
  modport slave  (input req, addr, wbe, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/spram_byte_write_arb2.sv
// Two-channel arbitrated front end for a single-port byte-write RAM with tagged response pipeline.
// Optional macro SPRAM_ARB2_FIXED_PRIO_EN: channel A always wins contention (default is round-robin).
module spram_byte_write_arb2 #(
  parameter int    NB_COL    = 4,
  parameter int    COL_WIDTH = 8,
  parameter int    RAM_DEPTH = 1024,
  parameter string RD_MODE   = "WRITE_FIRST",
  parameter int    OUT_REG   = 1,
  parameter string INIT_FILE = "",
  localparam int   AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int   DW        = NB_COL * COL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spram_byte_write_arb2_if.slave  a,
  spram_byte_write_arb2_if.slave  b
);
  localparam bit          MODE_WF = (RD_MODE == "WRITE_FIRST");
  localparam bit          MODE_NC = (RD_MODE == "NO_CHANGE");
  localparam logic [AW:0] DEPTH_W = (AW+1)'(RAM_DEPTH);

  logic              a_gnt, b_gnt;
  logic              acc_vld, acc_tag, in_range;
  logic [AW-1:0]     acc_addr;
  logic [NB_COL-1:0] acc_wbe;
  logic [DW-1:0]     acc_wdata;
  logic [DW-1:0]     mem [RAM_DEPTH];
  logic [DW-1:0]     old_word, rd_nxt, rd_q;
  logic              v1, tag1;
  logic              resp_v, resp_tag;
  logic [DW-1:0]     resp_data;
  logic              a_rv, b_rv;
  logic [DW-1:0]     a_hold, b_hold;

`ifdef SPRAM_ARB2_FIXED_PRIO_EN
  always_comb begin
    a_gnt = a.req;
    b_gnt = b.req & ~a.req;
  end
`else
  // prio_b = 1 means B wins the next contended cycle
  logic prio_b, prio_b_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_b <= 1'b0;
    else        prio_b <= prio_b_nxt;
  end

  always_comb begin
    prio_b_nxt = prio_b;
    if (a_gnt)      prio_b_nxt = 1'b1;
    else if (b_gnt) prio_b_nxt = 1'b0;
  end

  always_comb begin
    a_gnt = a.req & (~b.req | ~prio_b);
    b_gnt = b.req & (~a.req |  prio_b);
  end
`endif

  assign a.ready   = a_gnt;
  assign b.ready   = b_gnt;
  assign acc_vld   = a_gnt | b_gnt;
  assign acc_tag   = b_gnt;
  assign acc_addr  = b_gnt ? b.addr  : a.addr;
  assign acc_wbe   = b_gnt ? b.wbe   : a.wbe;
  assign acc_wdata = b_gnt ? b.wdata : a.wdata;
  assign in_range  = ({1'b0, acc_addr} < DEPTH_W);
  assign old_word  = in_range ? mem[acc_addr] : '0;

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (acc_vld && in_range) begin
      for (int i = 0; i < NB_COL; i++)
        if (acc_wbe[i]) mem[acc_addr][i*COL_WIDTH +: COL_WIDTH] <= acc_wdata[i*COL_WIDTH +: COL_WIDTH];
    end
  end

  // Out-of-range accesses always return zero, whatever the read mode.
  always_comb begin
    rd_nxt = old_word;
    if (!in_range) begin
      rd_nxt = '0;
    end else if (MODE_WF) begin
      for (int i = 0; i < NB_COL; i++)
        if (acc_wbe[i]) rd_nxt[i*COL_WIDTH +: COL_WIDTH] = acc_wdata[i*COL_WIDTH +: COL_WIDTH];
    end else if (MODE_NC && (|acc_wbe)) begin
      rd_nxt = rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      tag1 <= 1'b0;
      rd_q <= '0;
    end else begin
      v1 <= acc_vld;
      if (acc_vld) begin
        tag1 <= acc_tag;
        rd_q <= rd_nxt;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic          v2, tag2;
    logic [DW-1:0] d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2   <= 1'b0;
        tag2 <= 1'b0;
        d2   <= '0;
      end else begin
        v2 <= v1;
        if (v1) begin
          tag2 <= tag1;
          d2   <= rd_q;
        end
      end
    end

    assign resp_v    = v2;
    assign resp_tag  = tag2;
    assign resp_data = d2;
  end else begin : g_no_out_reg
    assign resp_v    = v1;
    assign resp_tag  = tag1;
    assign resp_data = rd_q;
  end

  assign a_rv = resp_v & ~resp_tag;
  assign b_rv = resp_v &  resp_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      if (a_rv) a_hold <= resp_data;
      if (b_rv) b_hold <= resp_data;
    end
  end

  assign a.rvalid = a_rv;
  assign b.rvalid = b_rv;
  assign a.rdata  = a_rv ? resp_data : a_hold;
  assign b.rdata  = b_rv ? resp_data : b_hold;
endmodule
